// File: rtl/avalon_mv_fetch.sv
// rtl/avalon_mv_fetch.sv - Avalon-MM read master that fetches matrix A and vector B, then computes C = A*B
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, base_addr    begin a fetch from word address base_addr (accepted in IDLE/DONE)
//   avm_*               pipelined Avalon-MM read master (waitrequest / readdatavalid)
//   a_matrix, b_vector  fetched operands
//   c_vector            unsigned product A*B
//   mult_valid          operands fully loaded
//   calc_done           c_vector valid
//   busy                fetch or MAC in progress
module avalon_mv_fetch #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int DW      = 8,
  parameter int AW      = 16,
  parameter int MAX_OUT = 4,
  parameter int RW      = 2*DW + ((COLS > 1) ? $clog2(COLS) : 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [AW-1:0]                     base_addr,
  output logic [AW-1:0]                     avm_address,
  output logic                              avm_read,
  input  logic                              avm_waitrequest,
  input  logic [DW-1:0]                     avm_readdata,
  input  logic                              avm_readdatavalid,
  output logic [ROWS-1:0][COLS-1:0][DW-1:0] a_matrix,
  output logic [COLS-1:0][DW-1:0]           b_vector,
  output logic [ROWS-1:0][RW-1:0]           c_vector,
  output logic                              mult_valid,
  output logic                              calc_done,
  output logic                              busy
);

  localparam int NE = ROWS*COLS;
  localparam int N  = NE + COLS;
  localparam int CW = $clog2(N+1);
  localparam int OW = $clog2(MAX_OUT+1);
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_R = CW'(N-1);
  localparam logic [OW-1:0] MAX_C  = OW'(MAX_OUT);
  localparam logic [IW-1:0] LAST_I = IW'(ROWS-1);
  localparam logic [KW-1:0] LAST_K = KW'(COLS-1);

  typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   base_q;
  logic [CW-1:0]   issue_cnt, ret_cnt;
  logic [OW-1:0]   outstanding;
  logic [IW-1:0]   mac_i;
  logic [KW-1:0]   mac_k;
  logic [RW-1:0]   acc, sum;
  logic [2*DW-1:0] prod;
  logic            start_ok, accept, ret, last_ret, last_mac;

  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // Request side depends only on registered state, never on waitrequest,
  // so address/read stay stable while the slave stalls.
  assign avm_read    = (state == FETCH) && (issue_cnt < N_C) && (outstanding < MAX_C);
  assign avm_address = base_q + AW'(issue_cnt);
  assign accept      = avm_read && !avm_waitrequest;

  // Responses outside FETCH (e.g. stragglers after a reset) are dropped.
  assign ret      = (state == FETCH) && avm_readdatavalid && (ret_cnt < N_C);
  assign last_ret = ret && (ret_cnt == LAST_R);
  assign last_mac = (state == MAC) && (mac_i == LAST_I) && (mac_k == LAST_K);

  assign prod = a_matrix[mac_i][mac_k] * b_vector[mac_k];
  assign sum  = ((mac_k == '0) ? '0 : acc) + RW'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nx = FETCH;
      FETCH: begin
        busy = 1'b1;
        if (last_ret) state_nx = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (last_mac) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
      mac_i       <= '0;
      mac_k       <= '0;
      acc         <= '0;
      a_matrix    <= '0;
      b_vector    <= '0;
      c_vector    <= '0;
      mult_valid  <= 1'b0;
      calc_done   <= 1'b0;
    end else if (start_ok) begin
      base_q      <= base_addr;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
      mac_i       <= '0;
      mac_k       <= '0;
      acc         <= '0;
      a_matrix    <= '0;
      b_vector    <= '0;
      c_vector    <= '0;
      mult_valid  <= 1'b0;
      calc_done   <= 1'b0;
    end else begin
      if (accept) issue_cnt <= issue_cnt + 1'b1;

      // Accept and return in the same cycle cancel out.
      case ({accept, ret})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      // Responses arrive in issue order, so ret_cnt is the element index:
      // the first NE words are A row-major, the last COLS words are B.
      if (ret) begin
        ret_cnt <= ret_cnt + 1'b1;
        for (int i = 0; i < ROWS; i++)
          for (int k = 0; k < COLS; k++)
            if (ret_cnt == CW'(i*COLS + k)) a_matrix[i][k] <= avm_readdata;
        for (int k = 0; k < COLS; k++)
          if (ret_cnt == CW'(NE + k)) b_vector[k] <= avm_readdata;
        if (last_ret) mult_valid <= 1'b1;
      end

      if (state == MAC) begin
        acc <= sum;
        if (mac_k == LAST_K) begin
          c_vector[mac_i] <= sum;
          mac_k           <= '0;
          mac_i           <= mac_i + 1'b1;
          if (last_mac) calc_done <= 1'b1;
        end else begin
          mac_k <= mac_k + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/avalon_mv_fetch.md
# avalon_mv_fetch

Parametrised Avalon-MM read master that fetches a ROWS×COLS matrix A and a COLS-element vector B from a memory-mapped slave. It holds both in register arrays and then computes C = A·B with a single sequential MAC. It generalises the fixed 8×8/8-bit matrix loader used by the mini-lab top level, adding the following:
- pipelined reads with `waitrequest`/`readdatavalid`
- a bounded outstanding-read count
- a programmable base address
- on-block result computation

It sits between the system interconnect and downstream consumers of `a_matrix`/`b_vector`/`c_vector`.

## Interface
- ROWS, 8: matrix rows (≥1)
- COLS, 8: matrix columns = vector length (≥1)
- DW, 8: element width in bits
- AW, 16: Avalon word-address width
- MAX_OUT, 4: max reads in flight (1..15)
- RW, 2*DW+$clog2(COLS) (min 2*DW+1): result element width
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse; begins fetch when idle or done
- base_addr  in  AW  word address of A[0][0]; sampled on accepted start
- avm_address  out  AW  read word address
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DW  read data (element = full bus)
- avm_readdatavalid  in  1  read data valid, returns in issue order
- a_matrix  out  [ROWS][COLS]×DW  fetched matrix
- b_vector  out  [COLS]×DW  fetched vector
- c_vector  out  [ROWS]×RW  unsigned product A·B
- mult_valid  out  1  A/B fully loaded (level)
- calc_done  out  1  c_vector valid (level)
- busy  out  1  state ≠ IDLE/DONE

## Operation
- Address map, N = ROWS*COLS + COLS words:
  - A[i][k] is at base + i*COLS + k.
  - B[k] is at base + ROWS*COLS + k.
  - Address arithmetic wraps modulo 2^AW.
- States and transitions:
  - IDLE → FETCH on start.
  - FETCH → MAC when all N responses have been received.
  - MAC → DONE after ROWS*COLS MAC cycles.
  - DONE → FETCH on start.
  - start is ignored in FETCH/MAC.
- Accepting start from IDLE or DONE clears mult_valid, calc_done, a_matrix, b_vector and c_vector. It also latches base_addr and zeroes both counters.
- Issue side (FETCH):
  - issue_cnt counts 0..N-1.
  - avm_read=1 whenever issue_cnt<N and outstanding<MAX_OUT.
  - avm_address = base + issue_cnt.
  - A request is accepted on avm_read & !avm_waitrequest.
  - While stalled, avm_address and avm_read are held stable.
- Outstanding tracking: outstanding = issued − returned. Accept and return in the same cycle leaves it unchanged; it never exceeds MAX_OUT.
- Return side:
  - Responses are numbered by ret_cnt = 0..N-1.
  - Each avm_readdatavalid writes avm_readdata to element ret_cnt in address order.
  - readdatavalid outside FETCH, or beyond N responses, is ignored.
- MAC:
  - Row i, k = 0..COLS-1: acc = (k==0 ? 0 : acc) + A[i][k]*B[k], all unsigned.
  - At k=COLS-1, write c_vector[i] = final sum.
  - One product per cycle.
  - Sums use full RW width, so no overflow is possible.

## Timing
- Reset values of all outputs: avm_read=0, avm_address=0, all arrays 0, mult_valid=0, calc_done=0, busy=0.
- Reset is asynchronous: asserting rst_n mid-FETCH drops avm_read immediately. The state returns to IDLE and in-flight responses after release are ignored.
- avm_read rises the cycle after start.
- With zero waitrequest and MAX_OUT ≥ read latency L, one read is accepted per cycle.
- mult_valid rises the cycle after the Nth readdatavalid is captured; the state enters MAC on that same edge.
- calc_done rises ROWS*COLS cycles after mult_valid.
- busy is high from the cycle after start until calc_done rises.
- Outputs are registered; no combinational path from Avalon inputs to outputs except none on avm_read (avm_read depends only on registered counters).

## Test plan
- Defaults, slave word n holds (n+1)&0xFF, L=1, no stalls, base=0:
  - expect A[i][k]=8i+k+1 and B[k]=65+k.
  - expect c_vector[0]=2508 and c_vector[7]=33196.
  - expect mult_valid 72 cycles after the first accept.
  - expect calc_done 64 cycles after mult_valid.
- Random waitrequest (50%):
  - avm_address/avm_read stay stable during every stall.
  - Same final A/B/C as the first scenario.
- MAX_OUT=2, L=4:
  - outstanding never exceeds 2 (bench counter).
  - avm_read low when 2 reads are in flight.
  - Results correct.
- All memory 0xFF → every c_vector element = 520200; no truncation.
- Back-to-back:
  - start pulsed during FETCH is ignored.
  - start in DONE with base_addr=0xFFF0 wraps addresses past 0xFFFF.
  - mult_valid/calc_done clear the cycle after start.
- rst_n low for 1 cycle mid-FETCH:
  - outputs zero immediately.
  - late readdatavalid is ignored.
  - A fresh start completes correctly.
